comp_arbiter: RTL and testbench

- Shares one magnitude comparator among NREQ requesters using round-robin arbitration.
- Each requester presents an operand pair with a valid/ready handshake.
- The block registers the operands, evaluates gt/lt/eq on the next cycle and holds a tagged response until the consumer accepts it.
- It sits between scheduled datapath operations and the single comparator resource, so only one comparator instance is needed per datapath.

---
 rtl/comp_arb_pkg.sv | 44 ++++
 rtl/comp_core.sv | 32 +++
 rtl/comp_arbiter.sv | 134 +++++++++++++
 tb/tb_comp_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/comp_arb_pkg.sv
// comp_arb_pkg
//    Shared types and helpers for the round-robin comparator arbiter.
//    - arb_state_e : arbiter FSM state encoding
//    - cmp_flags_t : {gt, lt, eq} comparison result
//    - rr_winner() : round-robin winner index from a request vector and pointer
//    The configuration macro COMP_ARB_SIGNED_EN is not used here; it only
//    affects comp_core.
package comp_arb_pkg;

   localparam int MAX_NREQ = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic gt;
      logic lt;
      logic eq;
   } cmp_flags_t;

   // First set bit of valid at or after ptr, wrapping modulo nreq.
   // Returns 0 when nothing is set; callers qualify with |valid.
   function automatic logic [3:0] rr_winner(input logic [MAX_NREQ-1:0] valid,
                                            input logic [3:0]          ptr,
                                            input int                  nreq);
      logic [3:0] win;
      logic       found;
      int         idx;
      win   = '0;
      found = 1'b0;
      for (int i = 0; i < MAX_NREQ; i++) begin
         idx = (int'(ptr) + i) % nreq;
         if (i < nreq && !found && valid[idx]) begin
            win   = 4'(idx);
            found = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/comp_core.sv
// comp_core
//    Combinational magnitude comparator, usable on its own as the shared
//    comparator resource of a datapath.
//    Ports:
//       a, b  : DATAWIDTH-bit operands
//       flags : {gt, lt, eq}, exactly one bit set
//    Build option:
//       COMP_ARB_SIGNED_EN defined   -> operands compared as two's complement
//       COMP_ARB_SIGNED_EN undefined -> unsigned comparison
module comp_core
   import comp_arb_pkg::*;
#(
   parameter int DATAWIDTH = 8
) (
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] b,
   output cmp_flags_t           flags
);

   always_comb begin
      flags = '0;
`ifdef COMP_ARB_SIGNED_EN
      flags.gt = ($signed(a) > $signed(b));
      flags.lt = ($signed(a) < $signed(b));
`else
      flags.gt = (a > b);
      flags.lt = (a < b);
`endif
      flags.eq = (a == b);
   end

endmodule

// File: rtl/comp_arbiter.sv
// comp_arbiter
//    Round-robin arbiter sharing one comp_core among NREQ requesters.
//    A granted operand pair is registered, compared the following cycle and
//    the tagged result held until the consumer takes it.
//    Ports:
//       clk, rst_n           : clock (rising edge), async active-low reset
//       req_valid/req_ready  : per-requester handshake, req_ready one-hot
//       req_a, req_b         : packed operands, slice i belongs to requester i
//       rsp_valid/rsp_ready  : response handshake
//       rsp_id               : index of the requester served
//       gt, lt, eq           : comparison result
//    Build option: COMP_ARB_SIGNED_EN selects signed comparison (in comp_core).
//
//    state | meaning
//    ------+--------------------------------------------------------------
//    IDLE  | waiting for requests; grants the round-robin winner
//    CMP   | operands registered; comparator result captured this cycle
//    RESP  | response presented; held until rsp_ready, then rr_ptr moves
module comp_arbiter
   import comp_arb_pkg::*;
#(
   parameter int DATAWIDTH = 8,
   parameter int NREQ      = 4,
   parameter int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [NREQ*DATAWIDTH-1:0] req_a,
   input  logic [NREQ*DATAWIDTH-1:0] req_b,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [IDW-1:0]            rsp_id,
   output logic                      gt,
   output logic                      lt,
   output logic                      eq
);

   arb_state_e           state_q, state_d;
   logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]       op_id_q, op_id_d;
   logic [DATAWIDTH-1:0] op_a_q, op_a_d;
   logic [DATAWIDTH-1:0] op_b_q, op_b_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]       rsp_id_q, rsp_id_d;
   cmp_flags_t           flags_q, flags_d;
   cmp_flags_t           core_flags;
   logic [MAX_NREQ-1:0]  valid_ext;
   logic [IDW-1:0]       winner;

   comp_core #(
      .DATAWIDTH (DATAWIDTH)
   ) u_core (
      .a     (op_a_q),
      .b     (op_b_q),
      .flags (core_flags)
   );

   always_comb begin
      valid_ext = MAX_NREQ'(req_valid);
      winner    = IDW'(rr_winner(valid_ext, 4'(rr_ptr_q), NREQ));
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      op_id_d     = op_id_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      flags_d     = flags_q;
      req_ready   = '0;
      case (state_q)
         IDLE: begin
            // req_ready is combinational, so it is masked while reset is held
            // to keep requesters from seeing a grant that cannot be taken.
            if (|req_valid && rst_n) begin
               req_ready[winner] = 1'b1;
               op_a_d  = req_a[winner*DATAWIDTH +: DATAWIDTH];
               op_b_d  = req_b[winner*DATAWIDTH +: DATAWIDTH];
               op_id_d = winner;
               state_d = CMP;
            end
         end
         CMP: begin
            flags_d     = core_flags;
            rsp_id_d    = op_id_q;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               // Pointer moves only on completion, to the slot after the
               // requester just served.
               rr_ptr_d    = (op_id_q == IDW'(NREQ - 1)) ? '0 : op_id_q + 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         op_id_q     <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         flags_q     <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         op_id_q     <= op_id_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         flags_q     <= flags_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign gt        = flags_q.gt;
   assign lt        = flags_q.lt;
   assign eq        = flags_q.eq;

endmodule

// File: tb/tb_comp_arbiter.sv
module tb_comp_arbiter;

   localparam int DW = 8;
   localparam int NR = 4;
   localparam int IW = 2;

   localparam logic [2:0] F_GT = 3'b100;
   localparam logic [2:0] F_LT = 3'b010;
   localparam logic [2:0] F_EQ = 3'b001;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [NR-1:0]    req_valid = '0;
   logic [NR-1:0]    req_ready;
   logic [NR*DW-1:0] req_a = '0;
   logic [NR*DW-1:0] req_b = '0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic [IW-1:0]    rsp_id;
   logic             gt, lt, eq;

   comp_arbiter #(.DATAWIDTH(DW), .NREQ(NR)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .gt        (gt),
      .lt        (lt),
      .eq        (eq)
   );

   always #5 clk = ~clk;

   int            n_checks = 0;
   int            n_fail   = 0;
   int            cyc      = 0;
   logic [NR-1:0] hold_mask = '0;
   logic [NR-1:0] last_gnt  = '0;
   int            gnt_ids[$];
   int            gnt_cycs[$];
   logic [4:0]    exp_q[$];       // {id[1:0], gt, lt, eq}

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] mk(input int id, input logic [2:0] f);
      return {2'(id), f};
   endfunction

   task automatic set_op(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b);
      req_a[idx*DW +: DW] = a;
      req_b[idx*DW +: DW] = b;
   endtask

   // One clock: note any grant about to be taken, step past the edge, drop
   // valid of the granted requester (unless held), return at negedge+1.
   task automatic tick();
      #1;
      last_gnt = rst_n ? req_ready : '0;
      for (int i = 0; i < NR; i++)
         if (last_gnt[i]) begin
            gnt_ids.push_back(i);
            gnt_cycs.push_back(cyc);
         end
      @(posedge clk);
      #1;
      cyc++;
      req_valid = req_valid & ~(last_gnt & ~hold_mask);
      @(negedge clk);
      #1;
   endtask

   task automatic monitor();
      logic          pv, pr;
      logic [IW-1:0] pid;
      logic [2:0]    pf;
      logic [4:0]    e;
      pv = 1'b0; pr = 1'b0; pid = '0; pf = '0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            pv = 1'b0;
            continue;
         end
         if (rsp_valid)
            check("rsp_onehot", 32'($countones({gt, lt, eq})), 1);
         if (pv && !pr) begin
            check("hold_valid", rsp_valid, 1);
            check("hold_id", rsp_id, pid);
            check("hold_flags", {gt, lt, eq}, pf);
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_rsp: got id %0d flags %b, no response expected", rsp_id, {gt, lt, eq});
            end else begin
               e = exp_q.pop_front();
               check("rsp_id", rsp_id, e[4:3]);
               check("rsp_flags", {gt, lt, eq}, e[2:0]);
            end
         end
         pv = rsp_valid; pr = rsp_ready; pid = rsp_id; pf = {gt, lt, eq};
      end
   endtask

   initial begin
      fork
         monitor();
      join_none

      // reset state
      @(negedge clk);
      #1;
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_flags", {gt, lt, eq}, 0);
      rst_n = 1'b1;

      // fairness: all four held, rr_ptr=0 -> 0,1,2,3,0 every 3 cycles
      set_op(0, 8'd10, 8'd20);
      set_op(1, 8'd30, 8'd30);
      set_op(2, 8'd200, 8'd100);
      set_op(3, 8'd0, 8'd1);
      exp_q.push_back(mk(0, F_LT));
      exp_q.push_back(mk(1, F_EQ));
      exp_q.push_back(mk(2, F_GT));
      exp_q.push_back(mk(3, F_LT));
      exp_q.push_back(mk(0, F_LT));
      rsp_ready = 1'b1;
      hold_mask = '1;
      req_valid = 4'b1111;
      repeat (13) tick();
      req_valid = '0;
      hold_mask = '0;
      repeat (2) tick();
      check("fair_count", gnt_ids.size(), 5);
      if (gnt_ids.size() == 5) begin
         check("fair_id0", gnt_ids[0], 0);
         check("fair_id1", gnt_ids[1], 1);
         check("fair_id2", gnt_ids[2], 2);
         check("fair_id3", gnt_ids[3], 3);
         check("fair_id4", gnt_ids[4], 0);
         for (int i = 1; i < 5; i++)
            check("fair_spacing", gnt_cycs[i] - gnt_cycs[i-1], 3);
      end

      // single request on requester 2 (rr_ptr=1)
      set_op(2, 8'd5, 8'd3);
      exp_q.push_back(mk(2, F_GT));
      req_valid = 4'b0100;
      #1;
      check("single_ready", req_ready, 4'b0100);
      tick();
      check("single_cmp_ready", req_ready, 0);
      check("single_cmp_valid", rsp_valid, 0);
      tick();
      check("single_rsp_valid", rsp_valid, 1);
      check("single_rsp_id", rsp_id, 2);
      check("single_gt", gt, 1);
      tick();
      check("single_done", rsp_valid, 0);

      // equality on requester 0 (rr_ptr=3)
      set_op(0, 8'hFF, 8'hFF);
      exp_q.push_back(mk(0, F_EQ));
      req_valid = 4'b0001;
      repeat (3) tick();

      // backpressure: 1 and 2 pending, rr_ptr=1 -> 1 served and stalled
      set_op(1, 8'h40, 8'h41);
      set_op(2, 8'h99, 8'h10);
      exp_q.push_back(mk(1, F_LT));
      exp_q.push_back(mk(2, F_GT));
      rsp_ready = 1'b0;
      req_valid = 4'b0110;
      tick();
      tick();
      for (int k = 0; k < 5; k++) begin
         check("bp_ready", req_ready, 0);
         check("bp_valid", rsp_valid, 1);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      check("bp_resume", req_ready, 4'b0100);
      repeat (3) tick();

      // signedness on requester 1 (rr_ptr=3)
      set_op(1, 8'h80, 8'h01);
`ifdef COMP_ARB_SIGNED_EN
      exp_q.push_back(mk(1, F_LT));
`else
      exp_q.push_back(mk(1, F_GT));
`endif
      req_valid = 4'b0010;
      repeat (3) tick();

      // reset while in CMP (rr_ptr=2): transaction dropped, pointer cleared
      set_op(2, 8'd1, 8'd2);
      req_valid = 4'b0100;
      tick();
      rst_n = 1'b0;
      set_op(1, 8'd3, 8'd3);
      set_op(3, 8'd9, 8'd4);
      req_valid = 4'b1010;
      #1;
      check("rstmid_req_ready", req_ready, 0);
      check("rstmid_rsp_valid", rsp_valid, 0);
      check("rstmid_rsp_id", rsp_id, 0);
      check("rstmid_flags", {gt, lt, eq}, 0);
      repeat (2) tick();
      check("rstmid_held", rsp_valid, 0);
      rst_n = 1'b1;
      exp_q.push_back(mk(1, F_EQ));
      exp_q.push_back(mk(3, F_GT));
      #1;
      check("rstrel_ready", req_ready, 4'b0010);
      repeat (8) tick();

      check("queue_empty", exp_q.size(), 0);
      check("final_idle", rsp_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
